// File: rtl/uart_tx_if.sv
// uart_tx byte handshake: producer drives data/valid,
// transmitter answers with ready.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser, MSB first, idle high, pairs with uart_rx.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter  int CLKS_PER_BIT = 1,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  up,
    output logic      tx
);

    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be 1 or more");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_d;
    logic             bit_end;
    logic             accept;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end  = (cnt_q == LAST);
    assign up.ready = (state_q == IDLE) || (state_q == STOP && bit_end);
    assign accept   = up.valid && up.ready;

    // State and datapath registers; tx is registered so reset forces it high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state, baud/bit counters, shifter and the line level for the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = START;
                    shift_d = up.data;
`ifdef UART_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd7;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
`ifdef UART_TX_PARITY_EN
                    par_d   = par_q ^ shift_q[7];
`endif
                    if (idx_q == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (accept) begin
                        state_d = START;
                        shift_d = up.data;
`ifdef UART_TX_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[7];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that feeds the existing uart_rx; `tx` connects directly to the receiver's `rx` input.
- Accepts a byte over a valid/ready handshake and serialises one frame on `tx`:
  - start bit (0), 8 data bits MSB-first, stop bit (1).
- Bit order and idle-high level match uart_rx: the first data bit sent lands in bit 7 of the receiver's `data`.
- Bit period is set by a parameter. The default of 1 clock per bit matches uart_rx's one-sample-per-clock operation.

Parameters:
- CLKS_PER_BIT, 1: clock cycles per serial bit; legal range is 1 or more.
- CNT_W, $clog2(CLKS_PER_BIT)+1: width of the baud counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- data  input  8  byte to send; sampled only on the accept edge.
- valid  input  1  `data` is valid; may drop the cycle after acceptance.
- ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idles high (1).

Behaviour:
- Reset:
  - While `rst` is high: `tx`=1, state=IDLE, baud counter=0, bit index=0, shift register=0.
  - After reset: `ready`=1.
  - Assertion mid-frame aborts the frame and forces `tx` high immediately (asynchronous), not at the next edge.
- `tx` is driven from a register, so no combinational path exists from `data` or `valid` to `tx`.
- Accept rule: an edge where `valid` && `ready` latches `data` into the shift register and enters START.
  - START begins on that same edge, so `tx`=0 from the cycle after acceptance.
  - `data` and `valid` are ignored whenever `ready`=0.
- ready = (state==IDLE) || (state==STOP && baud_cnt==CLKS_PER_BIT-1). This is combinational from state.
- States:
  - IDLE: `tx`=1. On accept, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 7.
  - DATA: `tx`=shift[7] for CLKS_PER_BIT cycles, then shift left by 1.
    - After 8 bits, go to STOP. With the optional feature enabled, go to PARITY instead.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
    - Accept in the final STOP cycle: go straight to START (back-to-back, no idle gap).
    - Otherwise: go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit.
  - Clears to 0 on every bit boundary and on accept.
  - With CLKS_PER_BIT=1 it stays at 0, and every cycle is a bit boundary.
- Frame length: exactly 10*CLKS_PER_BIT cycles, measured from the first `tx`=0 cycle to the end of the stop bit.
- Back-to-back sustained throughput: one byte per 10*CLKS_PER_BIT cycles.
- A `valid` that is held high with unchanged `data` after the final STOP accept sends the byte again. Upstream must drop `valid` after a handshake.
- Illegal values: CLKS_PER_BIT=0 is illegal and is caught by an elaboration-time `$error`.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - `tx` = XOR of the 8 latched data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
  - The 8 data bits are XOR-accumulated during DATA, so the shift register does not need to be re-read.
- Not defined:
  - No PARITY state and no parity logic; frame length is 10*CLKS_PER_BIT.
  - This is the required build for pairing with the current uart_rx, which has no parity support.

Test Plan:
- Reset idle, CPB=1:
  - Stimulus: hold `rst` 3 cycles, release, keep `valid`=0 for 5 cycles.
  - Required: `tx`=1 and `ready`=1 throughout.
- Single byte 8'hE0, CPB=1:
  - Stimulus: pulse `valid` for 1 cycle.
  - Required: `tx` over the following 10 cycles is 0,1,1,1,0,0,0,0,0,1; `ready`=0 for cycles 1-9 after accept.
- Loopback into uart_rx:
  - Stimulus: send 8'hC1.
  - Required: `rdy` rises at the end of the frame with receiver `data`=8'b11000001.
- Back-to-back, CPB=1:
  - Stimulus: 8'hA5 then 8'h3C, with `valid` held and `data` changed on the accept.
  - Required: 20 contiguous bit cycles, no idle bit between the frames; second frame is 0,0,0,1,1,1,1,0,0,1.
- Reset mid-frame, CPB=4:
  - Stimulus: accept 8'h00, then assert `rst` 13 cycles later.
  - Required: `tx` goes to 1 in the same cycle `rst` rises.
  - Required: after release, `ready`=1 and the next byte 8'hFF starts with a clean start bit of 4 cycles.
- UART_TX_PARITY_EN defined, CPB=2:
  - Stimulus: send 8'h07, then 8'h03.
  - Required: parity bits are 1 and 0 respectively, each held 2 cycles; frame length is 22 cycles.
